// File: rtl/div_ctrl_pkg.sv
// div_ctrl_pkg -- shared types and default constants for the div_ctrl
// programmable clock divider.
package div_ctrl_pkg;

   // Default divider counter / divisor width in bits.
   localparam int CNT_W_DEF       = 24;
   // Default divisor loaded at reset, in clk_in cycles per tick.
   localparam int DEFAULT_DIV_DEF = 5000000;

   // Controller states: IDLE accepts configuration, RUN counts.
   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

endpackage : div_ctrl_pkg

// File: rtl/div_ctrl_cnt.sv
// div_ctrl_cnt -- period counter for div_ctrl. Counts 0..divisor-1 while
// enabled, flags the terminal count, and registers the tick pulse that
// follows it. Holds at 0 whenever the enable is low.
module div_ctrl_cnt
   import div_ctrl_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk_in,
   input  logic             reset_n,
   input  logic             en,
   input  logic [CNT_W-1:0] divisor,
   output logic             wrap,
   output logic             tick
);

   logic [CNT_W-1:0] count;

   // Terminal-count compare; divisor is never 0, so divisor-1 never underflows.
   always_comb begin
      wrap = (count == (divisor - CNT_W'(1)));
   end

   // Period counter: clears when disabled, wraps at the terminal count.
   // NOTE: sequential state uses non-blocking (<=) so every register samples
   // pre-edge values; blocking here would create ordering-dependent races.
   always_ff @(posedge clk_in or negedge reset_n) begin
      if (!reset_n) begin
         count <= '0;
      end else if (!en) begin
         count <= '0;
      end else if (wrap) begin
         count <= '0;
      end else begin
         count <= count + CNT_W'(1);
      end
   end

   // Tick is high for the cycle after the counter sat at divisor-1.
   always_ff @(posedge clk_in or negedge reset_n) begin
      if (!reset_n) begin
         tick <= 1'b0;
      end else begin
         tick <= en && wrap;
      end
   end

endmodule : div_ctrl_cnt

// File: rtl/div_ctrl.sv
// div_ctrl -- programmable clock divider controller. Two-state FSM
// (IDLE/RUN), divisor capture while idle, divided clock output, and a
// period counter in div_ctrl_cnt.
// Optional feature: define DIV_CTRL_ONESHOT_EN to add the cfg_oneshot
// port and one-shot runs that end after the first tick with a done pulse.
module div_ctrl
   import div_ctrl_pkg::*;
#(
   parameter int CNT_W       = CNT_W_DEF,
   parameter int DEFAULT_DIV = DEFAULT_DIV_DEF
) (
   input  logic             clk_in,
   input  logic             reset_n,
   input  logic             start,
   input  logic             stop,
   input  logic             cfg_valid,
   input  logic [CNT_W-1:0] cfg_div,
`ifdef DIV_CTRL_ONESHOT_EN
   input  logic             cfg_oneshot,
`endif
   output logic             cfg_ready,
   output logic             tick,
   output logic             clk_out,
   output logic             busy,
   output logic             done
);

   state_t           state;
   state_t           next_state;
   logic [CNT_W-1:0] divisor;
   logic             oneshot;
   logic             run;
   logic             advance;
   logic             wrap;

   // State register.
   always_ff @(posedge clk_in or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic: stop wins over start, a one-shot run ends on its tick.
   // NOTE: next_state gets a default before the case so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (start && !stop) next_state = RUN;
         RUN:     if (stop || (oneshot && wrap)) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Output decode: configuration handshake and counter enable.
   always_comb begin
      run       = (state == RUN);
      cfg_ready = (state == IDLE);
      advance   = run && !stop;
   end

   // Divisor capture while idle; a zero request is stored as 1.
   always_ff @(posedge clk_in or negedge reset_n) begin
      if (!reset_n) begin
         divisor <= CNT_W'(DEFAULT_DIV);
      end else if (cfg_valid && cfg_ready) begin
         divisor <= (cfg_div == '0) ? CNT_W'(1) : cfg_div;
      end
   end

`ifdef DIV_CTRL_ONESHOT_EN
   // One-shot mode flag, captured together with the divisor.
   always_ff @(posedge clk_in or negedge reset_n) begin
      if (!reset_n) begin
         oneshot <= 1'b0;
      end else if (cfg_valid && cfg_ready) begin
         oneshot <= cfg_oneshot;
      end
   end

   // Done pulses alongside the tick that completes a one-shot run.
   always_ff @(posedge clk_in or negedge reset_n) begin
      if (!reset_n) begin
         done <= 1'b0;
      end else begin
         done <= advance && wrap && oneshot;
      end
   end
`else
   assign oneshot = 1'b0;
   assign done    = 1'b0;
`endif

   // Busy mirrors the state register one-for-one.
   always_ff @(posedge clk_in or negedge reset_n) begin
      if (!reset_n) begin
         busy <= 1'b0;
      end else begin
         busy <= (next_state == RUN);
      end
   end

   // Divided clock: toggles with each tick, forced low when a run is stopped.
   always_ff @(posedge clk_in or negedge reset_n) begin
      if (!reset_n) begin
         clk_out <= 1'b0;
      end else if (run && stop) begin
         clk_out <= 1'b0;
      end else if (advance && wrap) begin
         clk_out <= ~clk_out;
      end
   end

   div_ctrl_cnt #(
      .CNT_W (CNT_W)
   ) u_cnt (
      .clk_in  (clk_in),
      .reset_n (reset_n),
      .en      (advance),
      .divisor (divisor),
      .wrap    (wrap),
      .tick    (tick)
   );

endmodule : div_ctrl

// File: tb/tb_div_ctrl.sv
// tb_div_ctrl -- directed and randomized bench for div_ctrl, checked
// against a cycle-level behavioural model of the divider.
module tb_div_ctrl;

   localparam int CNT_W       = 24;
   localparam int DEFAULT_DIV = 5000000;
`ifdef DIV_CTRL_ONESHOT_EN
   localparam bit OS_EN = 1'b1;
`else
   localparam bit OS_EN = 1'b0;
`endif

   logic             clk_in = 1'b0;
   logic             reset_n = 1'b0;
   logic             start = 1'b0;
   logic             stop = 1'b0;
   logic             cfg_valid = 1'b0;
   logic [CNT_W-1:0] cfg_div = '0;
   logic             cfg_oneshot = 1'b0;
   logic             cfg_ready;
   logic             tick;
   logic             clk_out;
   logic             busy;
   logic             done;

   int checks = 0;
   int errors = 0;

   // Behavioural model: running flag, cycles elapsed since the RUN entry
   // edge, captured divisor/mode, and the expected registered outputs.
   bit m_run;
   int m_elapsed;
   int m_div;
   bit m_os;
   bit e_tick, e_clk, e_done;

   always #5 clk_in = ~clk_in;

   div_ctrl #(
      .CNT_W       (CNT_W),
      .DEFAULT_DIV (DEFAULT_DIV)
   ) dut (
      .clk_in      (clk_in),
      .reset_n     (reset_n),
      .start       (start),
      .stop        (stop),
      .cfg_valid   (cfg_valid),
      .cfg_div     (cfg_div),
`ifdef DIV_CTRL_ONESHOT_EN
      .cfg_oneshot (cfg_oneshot),
`endif
      .cfg_ready   (cfg_ready),
      .tick        (tick),
      .clk_out     (clk_out),
      .busy        (busy),
      .done        (done)
   );

   task automatic check(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0b expected=%0b at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_run = 1'b0; m_elapsed = 0; m_div = DEFAULT_DIV; m_os = 1'b0;
      e_tick = 1'b0; e_clk = 1'b0; e_done = 1'b0;
   endtask

   // One rising edge of the model, using the inputs presented before it.
   task automatic model_edge();
      e_tick = 1'b0;
      e_done = 1'b0;
      if (!m_run) begin
         if (cfg_valid) begin
            m_div = (cfg_div == '0) ? 1 : int'(cfg_div);
            m_os  = OS_EN && cfg_oneshot;
         end
         if (start && !stop) begin
            m_run = 1'b1;
            m_elapsed = 0;
         end
      end else if (stop) begin
         m_run = 1'b0;
         e_clk = 1'b0;
      end else begin
         m_elapsed++;
         if (m_elapsed % m_div == 0) begin
            e_tick = 1'b1;
            e_clk  = ~e_clk;
            if (m_os) begin
               e_done = 1'b1;
               m_run  = 1'b0;
            end
         end
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, ".tick"},      tick,      e_tick);
      check({tag, ".clk_out"},   clk_out,   e_clk);
      check({tag, ".busy"},      busy,      m_run);
      check({tag, ".cfg_ready"}, cfg_ready, !m_run);
      check({tag, ".done"},      done,      e_done);
   endtask

   // Present inputs, take one edge, then compare 1 ns after it.
   task automatic step(input string tag, input logic s, input logic p,
                       input logic v, input int d, input logic os);
      start = s; stop = p; cfg_valid = v; cfg_div = CNT_W'(d); cfg_oneshot = os;
      @(posedge clk_in);
      model_edge();
      #1;
      check_all(tag);
   endtask

   task automatic idle_steps(input string tag, input int n);
      for (int i = 0; i < n; i++) step(tag, 1'b0, 1'b0, 1'b0, 0, 1'b0);
   endtask

   initial begin
      model_reset();
      #12;
      check_all("reset");
      reset_n = 1'b1;

      // Divisor 4: tick every 4 cycles, clk_out period 8.
      step("cfg4", 1'b0, 1'b0, 1'b1, 4, 1'b0);
      step("start4", 1'b1, 1'b0, 1'b0, 0, 1'b0);
      idle_steps("run4", 20);

      // Divisor 0 stored as 1: tick every cycle.
      step("stop4", 1'b0, 1'b1, 1'b0, 0, 1'b0);
      step("cfg0", 1'b0, 1'b0, 1'b1, 0, 1'b0);
      step("start1", 1'b1, 1'b0, 1'b0, 0, 1'b0);
      idle_steps("run1", 6);

      // start+stop in IDLE stays idle; cfg in RUN is refused.
      step("stop1", 1'b0, 1'b1, 1'b0, 0, 1'b0);
      step("both", 1'b1, 1'b1, 1'b0, 0, 1'b0);
      check("both.busy_low", busy, 1'b0);
      step("cfg5", 1'b0, 1'b0, 1'b1, 5, 1'b0);
      step("start5", 1'b1, 1'b0, 1'b0, 0, 1'b0);
      step("cfg7_in_run", 1'b0, 1'b0, 1'b1, 7, 1'b0);
      step("restart_ign", 1'b1, 1'b0, 1'b0, 0, 1'b0);
      idle_steps("run5", 12);

      // Divisor 5: stop while counter is at 4 suppresses the tick.
      step("stop5", 1'b0, 1'b1, 1'b0, 0, 1'b0);
      step("start5b", 1'b1, 1'b0, 1'b0, 0, 1'b0);
      idle_steps("count5", 4);
      step("stop_at4", 1'b0, 1'b1, 1'b0, 0, 1'b0);
      check("stop_at4.tick_low", tick, 1'b0);
      check("stop_at4.clk_low", clk_out, 1'b0);

      // Divisor 10, async reset at counter 6.
      step("cfg10", 1'b0, 1'b0, 1'b1, 10, 1'b0);
      step("start10", 1'b1, 1'b0, 1'b0, 0, 1'b0);
      idle_steps("count10", 6);
      #2 reset_n = 1'b0;
      #1;
      model_reset();
      check_all("async_rst");
      #2 reset_n = 1'b1;
      step("start_def", 1'b1, 1'b0, 1'b0, 0, 1'b0);
      idle_steps("run_def", 20);
      step("stop_def", 1'b0, 1'b1, 1'b0, 0, 1'b0);

      // One-shot run, divisor 3.
      if (OS_EN) begin
         step("cfg_os", 1'b0, 1'b0, 1'b1, 3, 1'b1);
         step("start_os", 1'b1, 1'b0, 1'b0, 0, 1'b0);
         idle_steps("run_os", 5);
         check("os.clk_high", clk_out, 1'b1);
      end

      // Randomized traffic with small divisors.
      step("rnd_cfg", 1'b0, 1'b1, 1'b1, 3, 1'b0);
      step("rnd_cfg2", 1'b0, 1'b0, 1'b1, 3, 1'b0);
      for (int i = 0; i < 400; i++) begin
         step("rnd",
              ($urandom_range(0, 7) == 0),
              ($urandom_range(0, 15) == 0),
              ($urandom_range(0, 3) == 0),
              int'($urandom_range(0, 6)),
              logic'($urandom_range(0, 1)));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_div_ctrl
